alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 69 ++++++
 rtl/alu_pipe_if.sv | 33 +++
 rtl/alu_pipe_core.sv | 129 ++++++++++++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: FSM states, command encodings and
// the operand-requirement decode used by the capture logic.
// Optional multiply commands are enabled by defining ALU_PIPE_MUL_EN.
package alu_pipe_pkg;

   typedef enum logic [1:0] {StIdle, StWaitOpnd, StExec, StMul2} state_e;

   // Arithmetic commands (mode = 1)
   localparam int unsigned ACmdAdd    = 0;
   localparam int unsigned ACmdSub    = 1;
   localparam int unsigned ACmdAddCin = 2;
   localparam int unsigned ACmdSubCin = 3;
   localparam int unsigned ACmdIncA   = 4;
   localparam int unsigned ACmdDecA   = 5;
   localparam int unsigned ACmdIncB   = 6;
   localparam int unsigned ACmdDecB   = 7;
   localparam int unsigned ACmdCmp    = 8;
   localparam int unsigned ACmdMulInc = 9;
   localparam int unsigned ACmdMulShl = 10;

   // Logical commands (mode = 0)
   localparam int unsigned LCmdAnd  = 0;
   localparam int unsigned LCmdNand = 1;
   localparam int unsigned LCmdOr   = 2;
   localparam int unsigned LCmdNor  = 3;
   localparam int unsigned LCmdXor  = 4;
   localparam int unsigned LCmdXnor = 5;
   localparam int unsigned LCmdNotA = 6;
   localparam int unsigned LCmdNotB = 7;
   localparam int unsigned LCmdShrA = 8;
   localparam int unsigned LCmdShlA = 9;
   localparam int unsigned LCmdShrB = 10;
   localparam int unsigned LCmdShlB = 11;
   localparam int unsigned LCmdRol  = 12;
   localparam int unsigned LCmdRor  = 13;

   // Operand requirement masks: bit0 = A, bit1 = B
   localparam logic [1:0] NeedNone = 2'b00;
   localparam logic [1:0] NeedA    = 2'b01;
   localparam logic [1:0] NeedB    = 2'b10;
   localparam logic [1:0] NeedAB   = 2'b11;

   // Undefined commands need no operand so they complete straight away with ERR.
   function automatic logic [1:0] op_need(input logic mode, input int unsigned cmd);
      logic [1:0] need;
      need = NeedNone;
      if (mode) begin
         case (cmd)
            ACmdAdd, ACmdSub, ACmdAddCin, ACmdSubCin, ACmdCmp: need = NeedAB;
`ifdef ALU_PIPE_MUL_EN
            ACmdMulInc, ACmdMulShl: need = NeedAB;
`endif
            ACmdIncA, ACmdDecA: need = NeedA;
            ACmdIncB, ACmdDecB: need = NeedB;
            default: need = NeedNone;
         endcase
      end else begin
         case (cmd)
            LCmdAnd, LCmdNand, LCmdOr, LCmdNor, LCmdXor, LCmdXnor, LCmdRol, LCmdRor:
               need = NeedAB;
            LCmdNotA, LCmdShrA, LCmdShlA: need = NeedA;
            LCmdNotB, LCmdShrB, LCmdShlB: need = NeedB;
            default: need = NeedNone;
         endcase
      end
      return need;
   endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Command/operand/result bundle of the pipelined ALU.
// master drives commands and operands, slave (the ALU) drives results.
interface alu_pipe_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 4
);
   logic            ce;
   logic            mode;
   logic [CW-1:0]   cmd;
   logic [1:0]      inp_valid;
   logic [DW-1:0]   opa;
   logic [DW-1:0]   opb;
   logic            cin;
   logic [2*DW-1:0] res;
   logic            cout;
   logic            oflow;
   logic            err;
   logic            g;
   logic            e;
   logic            l;
   logic            res_valid;
   logic            busy;

   modport master (
      output ce, mode, cmd, inp_valid, opa, opb, cin,
      input  res, cout, oflow, err, g, e, l, res_valid, busy
   );

   modport slave (
      input  ce, mode, cmd, inp_valid, opa, opb, cin,
      output res, cout, oflow, err, g, e, l, res_valid, busy
   );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: captured operands and command in, result and flags out.
// The multiplier only exists when ALU_PIPE_MUL_EN is defined.
module alu_pipe_core
   import alu_pipe_pkg::*;
#(
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 4
) (
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic [CW-1:0]   cmd,
   input  logic            mode,
   input  logic            cin,
   output logic [2*DW-1:0] res,
   output logic            cout,
   output logic            oflow,
   output logic            err,
   output logic            g,
   output logic            e,
   output logic            l
);
   localparam int unsigned SW  = $clog2(DW);
   localparam logic [DW:0] One = {{DW{1'b0}}, 1'b1};

   int unsigned     cmd_int;
   logic [DW:0]     a_x, b_x, cin_x;
   logic [2*DW-1:0] rol_t, ror_t;
   logic            rot_err;

   assign cmd_int = 32'(cmd);
   assign a_x     = {1'b0, a};
   assign b_x     = {1'b0, b};
   assign cin_x   = {{DW{1'b0}}, cin};
   // Rotation via a doubled operand; the upper/lower half holds the rotated word.
   assign rol_t   = {a, a} << b[SW-1:0];
   assign ror_t   = {a, a} >> b[SW-1:0];
   assign rot_err = |(b >> SW);

`ifdef ALU_PIPE_MUL_EN
   logic [2*DW-1:0] mul_x, mul_y, prod;

   // Multiplier operands; 2*DW-bit product is the full RES width.
   always_comb begin
      if (cmd_int == ACmdMulShl) begin
         mul_x = {{(DW-1){1'b0}}, a, 1'b0};
         mul_y = {{(DW-1){1'b0}}, b_x};
      end else begin
         mul_x = {{(DW-1){1'b0}}, a_x + One};
         mul_y = {{(DW-1){1'b0}}, b_x + One};
      end
      prod = mul_x * mul_y;
   end
`endif

   logic [DW:0]   sum;
   logic [DW-1:0] lres;

   // Result and flag decode; bit DW of sum is the carry for adds, borrow for subtracts.
   always_comb begin
      sum   = '0;
      lres  = '0;
      res   = '0;
      cout  = 1'b0;
      oflow = 1'b0;
      err   = 1'b0;
      g     = 1'b0;
      e     = 1'b0;
      l     = 1'b0;
      if (mode) begin
         case (cmd_int)
            ACmdAdd, ACmdAddCin, ACmdIncA, ACmdIncB: begin
               case (cmd_int)
                  ACmdAdd:    sum = a_x + b_x;
                  ACmdAddCin: sum = a_x + b_x + cin_x;
                  ACmdIncA:   sum = a_x + One;
                  default:    sum = b_x + One;
               endcase
               res  = {{(DW-1){1'b0}}, sum};
               cout = sum[DW];
            end
            ACmdSub, ACmdSubCin, ACmdDecA, ACmdDecB: begin
               case (cmd_int)
                  ACmdSub:    sum = a_x - b_x;
                  ACmdSubCin: sum = a_x - b_x - cin_x;
                  ACmdDecA:   sum = a_x - One;
                  default:    sum = b_x - One;
               endcase
               res   = {{DW{1'b0}}, sum[DW-1:0]};
               oflow = sum[DW];
            end
            ACmdCmp: begin
               g = (a > b);
               e = (a == b);
               l = (a < b);
            end
`ifdef ALU_PIPE_MUL_EN
            ACmdMulInc, ACmdMulShl: res = prod;
`endif
            default: err = 1'b1;
         endcase
      end else begin
         case (cmd_int)
            LCmdAnd:  lres = a & b;
            LCmdNand: lres = ~(a & b);
            LCmdOr:   lres = a | b;
            LCmdNor:  lres = ~(a | b);
            LCmdXor:  lres = a ^ b;
            LCmdXnor: lres = ~(a ^ b);
            LCmdNotA: lres = ~a;
            LCmdNotB: lres = ~b;
            LCmdShrA: lres = a >> 1;
            LCmdShlA: lres = a << 1;
            LCmdShrB: lres = b >> 1;
            LCmdShlB: lres = b << 1;
            LCmdRol: begin
               lres = rol_t[2*DW-1:DW];
               err  = rot_err;
            end
            LCmdRor: begin
               lres = ror_t[DW-1:0];
               err  = rot_err;
            end
            default: err = 1'b1;
         endcase
         res = {{DW{1'b0}}, lres};
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU top: operand capture FSM, missing-operand timeout and registered outputs.
// Define ALU_PIPE_MUL_EN to enable MUL_INC/MUL_SHL (two-cycle latency via StMul2).
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int unsigned DW      = 8,
   parameter int unsigned CW      = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e          state_q;
   logic [7:0]      cnt_q;
   logic [1:0]      need_q;
   logic [DW-1:0]   a_q, b_q;
   logic [CW-1:0]   cmd_q;
   logic            mode_q, cin_q;
   logic [2*DW-1:0] res_q;
   logic            cout_q, oflow_q, err_q, g_q, e_q, l_q, res_valid_q;

   logic [1:0]      need_in;
   logic            op_mul;
   logic [2*DW-1:0] core_res;
   logic            core_cout, core_oflow, core_err, core_g, core_e, core_l;

   assign need_in = op_need(bus.mode, 32'(bus.cmd));

`ifdef ALU_PIPE_MUL_EN
   int unsigned cmd_q_int;
   assign cmd_q_int = 32'(cmd_q);
   assign op_mul    = mode_q && (cmd_q_int == ACmdMulInc || cmd_q_int == ACmdMulShl);
`else
   assign op_mul = 1'b0;
`endif

   alu_pipe_core #(
      .DW (DW),
      .CW (CW)
   ) u_core (
      .a     (a_q),
      .b     (b_q),
      .cmd   (cmd_q),
      .mode  (mode_q),
      .cin   (cin_q),
      .res   (core_res),
      .cout  (core_cout),
      .oflow (core_oflow),
      .err   (core_err),
      .g     (core_g),
      .e     (core_e),
      .l     (core_l)
   );

   // FSM, operand capture, timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         need_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cmd_q       <= '0;
         mode_q      <= 1'b0;
         cin_q       <= 1'b0;
         res_q       <= '0;
         cout_q      <= 1'b0;
         oflow_q     <= 1'b0;
         err_q       <= 1'b0;
         g_q         <= 1'b0;
         e_q         <= 1'b0;
         l_q         <= 1'b0;
         res_valid_q <= 1'b0;
      end else if (!bus.ce) begin
         // Everything holds; only the pulse is dropped so it cannot stretch.
         res_valid_q <= 1'b0;
      end else begin
         res_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.inp_valid != 2'b00) begin
                  mode_q <= bus.mode;
                  cmd_q  <= bus.cmd;
                  cin_q  <= bus.cin;
                  cnt_q  <= '0;
                  if (bus.inp_valid[0]) a_q <= bus.opa;
                  if (bus.inp_valid[1]) b_q <= bus.opb;
                  if ((bus.inp_valid & need_in) == need_in) begin
                     state_q <= StExec;
                  end else begin
                     need_q  <= need_in & ~bus.inp_valid;
                     state_q <= StWaitOpnd;
                  end
               end
            end
            StWaitOpnd: begin
               // Only the missing operand is taken; arrival wins over a same-cycle timeout.
               if ((bus.inp_valid & need_q) != 2'b00) begin
                  if (need_q[0]) a_q <= bus.opa;
                  if (need_q[1]) b_q <= bus.opb;
                  state_q <= StExec;
               end else if (cnt_q == CntLast) begin
                  res_q       <= '0;
                  cout_q      <= 1'b0;
                  oflow_q     <= 1'b0;
                  err_q       <= 1'b1;
                  g_q         <= 1'b0;
                  e_q         <= 1'b0;
                  l_q         <= 1'b0;
                  res_valid_q <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StExec:  state_q <= op_mul ? StMul2 : StIdle;
            StMul2:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
         if (state_q == StMul2 || (state_q == StExec && !op_mul)) begin
            res_q       <= core_res;
            cout_q      <= core_cout;
            oflow_q     <= core_oflow;
            err_q       <= core_err;
            g_q         <= core_g;
            e_q         <= core_e;
            l_q         <= core_l;
            res_valid_q <= 1'b1;
         end
      end
   end

   assign bus.res       = res_q;
   assign bus.cout      = cout_q;
   assign bus.oflow     = oflow_q;
   assign bus.err       = err_q;
   assign bus.g         = g_q;
   assign bus.e         = e_q;
   assign bus.l         = l_q;
   assign bus.res_valid = res_valid_q;
   assign bus.busy      = (state_q == StWaitOpnd) || (state_q == StMul2);

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (DW=8, CW=4, TIMEOUT=16): directed cases for
// latency, split operands, timeout, clock enable and reset, then random commands
// compared against an arithmetic reference model.
module tb_alu_pipe;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic rst;

   alu_pipe_if #(.DW(DW), .CW(CW)) bus ();

   alu_pipe #(
      .DW      (DW),
      .CW      (CW),
      .TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // flags = {cout, oflow, err, g, e, l}
   typedef struct packed {
      logic [15:0] res;
      logic [5:0]  flags;
   } out_t;

   int   errors = 0;
   int   checks = 0;
   out_t last;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] flags_now();
      return {bus.cout, bus.oflow, bus.err, bus.g, bus.e, bus.l};
   endfunction

   // Reference: result and flags straight from the operation definitions.
   function automatic out_t model(input logic m, input int unsigned c, input int unsigned a,
                                  input int unsigned b, input logic ci,
                                  output int unsigned lat);
      out_t        o;
      int unsigned r, cv, amt;
      logic        co, ov, er, gg, ee, ll;
      o = '0; r = 0; cv = ci; lat = 1;
      co = 0; ov = 0; er = 0; gg = 0; ee = 0; ll = 0;
      amt = b % 8;
      if (m) begin
         case (c)
            0:  begin r = a + b;      co = (r > 255); end
            1:  begin r = (a - b) & 255;      ov = (a < b); end
            2:  begin r = a + b + cv; co = (r > 255); end
            3:  begin r = (a - b - cv) & 255; ov = (a < b + cv); end
            4:  begin r = a + 1;      co = (r > 255); end
            5:  begin r = (a - 1) & 255; ov = (a == 0); end
            6:  begin r = b + 1;      co = (r > 255); end
            7:  begin r = (b - 1) & 255; ov = (b == 0); end
            8:  begin gg = (a > b); ee = (a == b); ll = (a < b); end
`ifdef ALU_PIPE_MUL_EN
            9:  begin r = ((a + 1) * (b + 1)) & 16'hFFFF; lat = 2; end
            10: begin r = (2 * a * b) & 16'hFFFF;         lat = 2; end
`endif
            default: er = 1;
         endcase
      end else begin
         case (c)
            0:  r = a & b;
            1:  r = ~(a & b) & 255;
            2:  r = a | b;
            3:  r = ~(a | b) & 255;
            4:  r = a ^ b;
            5:  r = ~(a ^ b) & 255;
            6:  r = ~a & 255;
            7:  r = ~b & 255;
            8:  r = a / 2;
            9:  r = (a * 2) & 255;
            10: r = b / 2;
            11: r = (b * 2) & 255;
            12: begin r = ((a << amt) | (a >> (8 - amt))) & 255; er = (b >= 8); end
            13: begin r = ((a >> amt) | (a << (8 - amt))) & 255; er = (b >= 8); end
            default: er = 1;
         endcase
      end
      o.res   = 16'(r);
      o.flags = {co, ov, er, gg, ee, ll};
      return o;
   endfunction

   task automatic run_op(input string tag, input logic m, input int unsigned c,
                         input int unsigned a, input int unsigned b, input logic ci,
                         input logic [1:0] v);
      out_t        exp;
      int unsigned lat, n;
      exp = model(m, c, a, b, ci, lat);
      bus.mode = m; bus.cmd = 4'(c); bus.opa = 8'(a); bus.opb = 8'(b);
      bus.cin = ci; bus.inp_valid = v;
      tick();
      // Scramble inputs after capture; the DUT must use captured values.
      bus.inp_valid = 2'b00; bus.opa = 8'($urandom); bus.opb = 8'($urandom);
      bus.cmd = 4'($urandom); bus.mode = 1'($urandom);
      check({tag, "_early"}, 64'(bus.res_valid), 64'(0));
      n = 0;
      while (!bus.res_valid && n < 6) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check({tag, "_res"}, 64'(bus.res), 64'(exp.res));
      check({tag, "_flags"}, 64'(flags_now()), 64'(exp.flags));
      last = exp;
      tick();
      check({tag, "_pulse"}, 64'(bus.res_valid), 64'(0));
      check({tag, "_hold"}, 64'(bus.res), 64'(exp.res));
   endtask

   initial begin
      int unsigned n;
      rst = 1'b1;
      bus.ce = 1'b1; bus.mode = 1'b0; bus.cmd = '0; bus.inp_valid = 2'b00;
      bus.opa = '0; bus.opb = '0; bus.cin = 1'b0;
      last = '0;
      tick();
      tick();
      check("rst_res", 64'(bus.res), 64'(0));
      check("rst_flags", 64'(flags_now()), 64'(0));
      check("rst_valid", 64'(bus.res_valid), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      rst = 1'b0;
      tick();

      // Directed single-shot operations
      run_op("add_ff_01", 1, 0, 8'hFF, 8'h01, 0, 2'b11);
      check("add_ff_01_const", 64'(last.res), 64'(16'h0100));
      run_op("cmp_lt", 1, 8, 5, 9, 0, 2'b11);
      run_op("cmp_eq", 1, 8, 9, 9, 0, 2'b11);
      run_op("cmp_gt", 1, 8, 9, 5, 0, 2'b11);
      run_op("sub_borrow", 1, 1, 3, 5, 0, 2'b11);
      run_op("subcin", 1, 3, 5, 5, 1, 2'b11);
      run_op("addcin", 1, 2, 8'hFF, 0, 1, 2'b11);
      run_op("inc_a_only", 1, 4, 8'hFF, 0, 0, 2'b01);
      run_op("dec_b_only", 1, 7, 0, 0, 0, 2'b10);
      run_op("not_b_only", 0, 7, 0, 8'h0F, 0, 2'b10);
      run_op("rol", 0, 12, 8'h81, 1, 0, 2'b11);
      run_op("rol_err", 0, 12, 8'h81, 9, 0, 2'b11);
      run_op("ror", 0, 13, 8'h01, 1, 0, 2'b11);
      run_op("mul_inc", 1, 9, 3, 4, 0, 2'b11);
      run_op("mul_shl", 1, 10, 8'hFF, 8'hFF, 0, 2'b11);
      run_op("undef_arith", 1, 12, 1, 2, 0, 2'b11);
      run_op("undef_logic", 0, 15, 1, 2, 0, 2'b11);

      // OPB five cycles after OPA; busy throughout, other inputs ignored on arrival
      bus.mode = 1; bus.cmd = 4'd0; bus.opa = 3; bus.opb = 8'hAA; bus.cin = 0;
      bus.inp_valid = 2'b01;
      tick();
      bus.inp_valid = 2'b00;
      check("split_busy0", 64'(bus.busy), 64'(1));
      for (int k = 1; k < 5; k++) begin
         tick();
         check("split_busy", 64'(bus.busy), 64'(1));
         check("split_novalid", 64'(bus.res_valid), 64'(0));
      end
      bus.inp_valid = 2'b11; bus.opb = 4; bus.opa = 8'h77; bus.cmd = 4'd1; bus.mode = 0;
      tick();
      bus.inp_valid = 2'b00;
      tick();
      check("split_valid", 64'(bus.res_valid), 64'(1));
      check("split_res", 64'(bus.res), 64'(7));
      check("split_flags", 64'(flags_now()), 64'(0));
      tick();

      // Timeout with OPB never arriving
      bus.mode = 1; bus.cmd = 4'd0; bus.opa = 9; bus.inp_valid = 2'b01;
      tick();
      bus.inp_valid = 2'b00;
      n = 0;
      while (!bus.res_valid && n < 40) begin
         check("to_busy", 64'(bus.busy), 64'(1));
         tick();
         n++;
      end
      check("to_cycles", 64'(n), 64'(TO));
      check("to_res", 64'(bus.res), 64'(0));
      check("to_flags", 64'(flags_now()), 64'(6'b001000));
      check("to_busy_low", 64'(bus.busy), 64'(0));
      tick();

      // Clock enable low freezes wait counter and outputs
      run_op("pre_ce", 1, 0, 8'h12, 8'h34, 0, 2'b11);
      bus.mode = 1; bus.cmd = 4'd0; bus.opa = 5; bus.inp_valid = 2'b01;
      tick();
      bus.inp_valid = 2'b00;
      for (int k = 0; k < 5; k++) tick();
      bus.ce = 1'b0;
      bus.inp_valid = 2'b10; bus.opb = 8'h11;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("ce_novalid", 64'(bus.res_valid), 64'(0));
         check("ce_busy", 64'(bus.busy), 64'(1));
         check("ce_res_hold", 64'(bus.res), 64'(last.res));
      end
      bus.inp_valid = 2'b00;
      bus.ce = 1'b1;
      n = 0;
      while (!bus.res_valid && n < 40) begin
         tick();
         n++;
      end
      check("ce_to_cycles", 64'(n), 64'(TO - 5));
      check("ce_to_err", 64'(bus.err), 64'(1));
      tick();

      // Reset during WAIT_OPND (with CE low) aborts; late OPB gives no result
      run_op("pre_rst", 1, 0, 8'h80, 8'h80, 0, 2'b11);
      bus.mode = 1; bus.cmd = 4'd0; bus.opa = 3; bus.inp_valid = 2'b01;
      tick();
      bus.inp_valid = 2'b00;
      tick();
      check("rw_busy", 64'(bus.busy), 64'(1));
      rst = 1'b1; bus.ce = 1'b0;
      tick();
      rst = 1'b0; bus.ce = 1'b1;
      check("rw_res", 64'(bus.res), 64'(0));
      check("rw_flags", 64'(flags_now()), 64'(0));
      check("rw_valid", 64'(bus.res_valid), 64'(0));
      check("rw_busy_low", 64'(bus.busy), 64'(0));
      bus.inp_valid = 2'b10; bus.opb = 4;
      tick();
      bus.inp_valid = 2'b00;
      for (int k = 0; k < 3; k++) begin
         check("rw_no_result", 64'(bus.res_valid), 64'(0));
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Random commands against the reference model
      for (int i = 0; i < 150; i++) begin
         run_op("rand", 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 255),
                $urandom_range(0, 255), 1'($urandom), 2'b11);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
